// File: rtl/key_event_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : key_event_queue_if
// Purpose  : Event-queue handshake bundle between key_event_queue and consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface key_event_queue_if;
  logic       Ev_Valid;
  logic       Ev_Ready;
  logic [5:0] Ev_Code;
  logic       Ev_Release;
  logic [4:0] Ev_Count;
  logic       Overflow;
  logic       Ovf_Clear;

  modport master (
    output Ev_Valid,
    output Ev_Code,
    output Ev_Release,
    output Ev_Count,
    output Overflow,
    input  Ev_Ready,
    input  Ovf_Clear
  );

  modport slave (
    input  Ev_Valid,
    input  Ev_Code,
    input  Ev_Release,
    input  Ev_Count,
    input  Overflow,
    output Ev_Ready,
    output Ovf_Clear
  );
endinterface
`default_nettype wire

// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : key_event_queue
// Purpose  : Debounces keypad codes and queues press/release events in a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_queue #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input wire               Clock,
  input wire               Reset,
  input wire  [5:0]        Keyb_Value,
  key_event_queue_if.master ev
);

  localparam int         C_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] C_CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] C_DEPTH   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [5:0] r_sample;
  logic [5:0] r_candidate;
  logic [7:0] r_stable_cnt;
  logic [5:0] r_accepted;
  logic [5:0] w_accepted_nxt;

  logic       w_accept;
  logic       w_push;
  logic       w_push_rel;
  logic [5:0] w_push_code;

  logic [6:0]         r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [4:0]         r_count;
  logic               r_overflow;
  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;
  logic [6:0]         w_head;

  // --------------------------------------------------------------------------
  // Input sample and debounce counter
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sample     <= 6'd0;
      r_candidate  <= 6'd0;
      r_stable_cnt <= 8'd0;
    end else begin
      r_sample <= Keyb_Value;
      if (r_sample != r_candidate) begin
        r_candidate  <= r_sample;
        r_stable_cnt <= 8'd0;
      end else if (r_stable_cnt != C_CNT_MAX) begin
        r_stable_cnt <= r_stable_cnt + 8'd1;
      end
    end
  end

  // Acceptance is held off in SWAP so the pending press is never lost.
  assign w_accept = (r_stable_cnt == C_CNT_MAX) &&
                    (r_sample == r_candidate)   &&
                    (r_candidate != r_accepted) &&
                    (r_state != ST_SWAP);

  // --------------------------------------------------------------------------
  // Key-state FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_accepted <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_accepted <= w_accepted_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accepted_nxt = r_accepted;
    w_push         = 1'b0;
    w_push_rel     = 1'b0;
    w_push_code    = 6'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_push         = 1'b1;
          w_push_code    = r_candidate;
          w_accepted_nxt = r_candidate;
          w_state_nxt    = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_accept) begin
          w_push         = 1'b1;
          w_push_rel     = 1'b1;
          w_push_code    = r_accepted;
          w_accepted_nxt = r_candidate;
          w_state_nxt    = (r_candidate == 6'd0) ? ST_IDLE : ST_SWAP;
        end
      end
      ST_SWAP: begin
        // Accepted already holds the new key; emit its press now.
        w_push      = 1'b1;
        w_push_code = r_accepted;
        w_state_nxt = ST_HELD;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Show-ahead event FIFO
  // --------------------------------------------------------------------------
  assign w_valid = (r_count != 5'd0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = w_valid && ev.Ev_Ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge Clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_push_rel, w_push_code};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop wins over a coincident clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ev.Ovf_Clear) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign ev.Ev_Valid   = w_valid;
  assign ev.Ev_Code    = w_valid ? w_head[5:0] : 6'd0;
  assign ev.Ev_Release = w_valid & w_head[6];
  assign ev.Ev_Count   = r_count;
  assign ev.Overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_queue
// Purpose  : Directed and randomized checks of key_event_queue against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_queue;

  localparam int D     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] keyb;
  logic       mon_en;

  key_event_queue_if eq_if ();

  key_event_queue #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Keyb_Value(keyb),
    .ev        (eq_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a key is accepted once it has been seen on D+1
  // consecutive edges; acceptance takes effect on the following edge.
  logic [6:0] mq[$];
  int         run;
  logic [5:0] key_prev;
  logic [5:0] m_acc;
  bit         m_swap;
  bit         m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      run = 0; key_prev = 6'd0; m_acc = 6'd0; m_swap = 0; m_ovf = 0;
    end else begin
      bit acc_now, push, pop, drop;
      logic [6:0] evt;
      acc_now = (run >= D + 1) && (key_prev != m_acc) && !m_swap;
      push = 0; evt = 7'd0;
      if (m_swap) begin
        push = 1; evt = {1'b0, m_acc}; m_swap = 0;
      end else if (acc_now) begin
        push = 1;
        if (m_acc == 6'd0) evt = {1'b0, key_prev};
        else begin
          evt = {1'b1, m_acc};
          if (key_prev != 6'd0) m_swap = 1;
        end
        m_acc = key_prev;
      end
      pop  = (mq.size() > 0) && eq_if.Ev_Ready;
      drop = push && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(evt);
      if (drop) m_ovf = 1;
      else if (eq_if.Ovf_Clear) m_ovf = 0;
      if (keyb == key_prev) begin
        if (run < 100000) run++;
      end else begin
        key_prev = keyb; run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic [6:0] head;
      head = (mq.size() > 0) ? mq[0] : 7'd0;
      check_eq("mon_valid", eq_if.Ev_Valid, (mq.size() > 0) ? 1 : 0);
      check_eq("mon_count", eq_if.Ev_Count, mq.size());
      check_eq("mon_code", eq_if.Ev_Code, head[5:0]);
      check_eq("mon_release", eq_if.Ev_Release, head[6]);
      check_eq("mon_overflow", eq_if.Overflow, m_ovf);
    end
  end

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_valid", eq_if.Ev_Valid, 0);
    check_eq("rst_count", eq_if.Ev_Count, 0);
    check_eq("rst_code", eq_if.Ev_Code, 0);
    check_eq("rst_release", eq_if.Ev_Release, 0);
    check_eq("rst_overflow", eq_if.Overflow, 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    logic [5:0] seq [5];
    rst = 1'b1; keyb = 6'd0; mon_en = 1'b0;
    eq_if.Ev_Ready = 1'b0; eq_if.Ovf_Clear = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("init_valid", eq_if.Ev_Valid, 0);
    check_eq("init_count", eq_if.Ev_Count, 0);
    check_eq("init_code", eq_if.Ev_Code, 0);
    check_eq("init_overflow", eq_if.Overflow, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Press latency from an idle keypad
    keyb = 6'd5; eq_if.Ev_Ready = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (eq_if.Ev_Valid) begin lat = n; break; end
    end
    check_eq("latency", lat, D + 2);
    check_eq("lat_code", eq_if.Ev_Code, 5);
    check_eq("lat_release", eq_if.Ev_Release, 0);
    @(posedge clk); #1;
    check_eq("lat_pulse", eq_if.Ev_Valid, 0);

    // Short glitch to zero
    @(negedge clk); keyb = 6'd0;
    repeat (10) @(negedge clk);
    keyb = 6'd5;
    repeat (2 * D) @(negedge clk);
    check_eq("glitch_count", eq_if.Ev_Count, 0);

    // Key swap 5 -> 9
    eq_if.Ev_Ready = 1'b0; keyb = 6'd9;
    repeat (D + 6) @(negedge clk);
    check_eq("swap_count", eq_if.Ev_Count, 2);
    check_eq("swap_head_code", eq_if.Ev_Code, 5);
    check_eq("swap_head_rel", eq_if.Ev_Release, 1);
    eq_if.Ev_Ready = 1'b1; @(negedge clk); eq_if.Ev_Ready = 1'b0;
    check_eq("swap_2nd_code", eq_if.Ev_Code, 9);
    check_eq("swap_2nd_rel", eq_if.Ev_Release, 0);
    eq_if.Ev_Ready = 1'b1; @(negedge clk); eq_if.Ev_Ready = 1'b0;

    // Overflow on a full queue
    keyb = 6'd0;
    pulse_reset();
    seq[0] = 6'd3; seq[1] = 6'd0; seq[2] = 6'd7; seq[3] = 6'd0; seq[4] = 6'd2;
    for (int i = 0; i < 5; i++) begin
      keyb = seq[i];
      repeat (D + 4) @(negedge clk);
    end
    check_eq("full_count", eq_if.Ev_Count, 4);
    check_eq("full_overflow", eq_if.Overflow, 1);
    check_eq("full_head_code", eq_if.Ev_Code, 3);
    check_eq("full_head_rel", eq_if.Ev_Release, 0);
    eq_if.Ovf_Clear = 1'b1; @(negedge clk); eq_if.Ovf_Clear = 1'b0;
    check_eq("ovf_cleared", eq_if.Overflow, 0);

    // Push and pop together while full
    keyb = 6'd0;
    repeat (D + 1) @(negedge clk);
    eq_if.Ev_Ready = 1'b1; @(negedge clk); eq_if.Ev_Ready = 1'b0;
    check_eq("pp_count", eq_if.Ev_Count, 4);
    check_eq("pp_overflow", eq_if.Overflow, 0);
    check_eq("pp_head_code", eq_if.Ev_Code, 3);
    check_eq("pp_head_rel", eq_if.Ev_Release, 1);
    eq_if.Ev_Ready = 1'b1; repeat (3) @(negedge clk); eq_if.Ev_Ready = 1'b0;
    check_eq("pp_tail_count", eq_if.Ev_Count, 1);
    check_eq("pp_tail_code", eq_if.Ev_Code, 2);
    check_eq("pp_tail_rel", eq_if.Ev_Release, 1);

    // Reset during SWAP
    pulse_reset();
    keyb = 6'd5;
    repeat (D + 4) @(negedge clk);
    check_eq("rs_press", eq_if.Ev_Count, 1);
    keyb = 6'd9;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      cnt = int'(eq_if.Ev_Count);
      if (cnt == 2) break;
    end
    check_eq("rs_swap_reached", cnt, 2);
    pulse_reset();
    repeat (D + 6) @(negedge clk);
    check_eq("rs_after_count", eq_if.Ev_Count, 1);
    check_eq("rs_after_code", eq_if.Ev_Code, 9);
    check_eq("rs_after_rel", eq_if.Ev_Release, 0);

    // Randomized traffic
    for (int seg = 0; seg < 120; seg++) begin
      logic [5:0] k;
      int hold;
      k = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D)) : int'($urandom_range(D + 1, 2 * D + 4));
      keyb = k;
      for (int c = 0; c < hold; c++) begin
        eq_if.Ev_Ready  = ($urandom_range(0, 3) == 0);
        eq_if.Ovf_Clear = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      if ($urandom_range(0, 29) == 0) pulse_reset();
    end
    eq_if.Ev_Ready = 1'b0; eq_if.Ovf_Clear = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
